// File: rtl/pano_button.sv
// Pushbutton conditioner: synchronizer, debouncer, press/release pulses, press counter.
// Define PANO_BUTTON_LONG_PRESS_EN to add the hold counter, LONG_HELD state and LONG_PRESS pulse.
module pano_button #(
  parameter int DEBOUNCE_CYCLES   = 250000,
  parameter int LONG_PRESS_CYCLES = 25000000,
  parameter bit ACTIVE_LOW        = 1'b1
) (
  input  logic       SYSCLK,
  input  logic       RESET_N,
  input  logic       BTN,
  output logic       BTN_LEVEL,
  output logic       PRESS,
  output logic       RELEASE,
  output logic       LONG_PRESS,
  output logic [7:0] PRESS_COUNT
);

  // Sized to hold DEBOUNCE_CYCLES itself so a count of 1 still yields a 1-bit counter.
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic IDLE_PIN = ACTIVE_LOW;

`ifdef PANO_BUTTON_LONG_PRESS_EN
  typedef enum logic [1:0] {RELEASED, PRESSED, LONG_HELD} state_t;
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
  logic              long_d;
`else
  typedef enum logic {RELEASED, PRESSED} state_t;
`endif

  state_t          state, state_d;
  logic            sync1, sync2, s;
  logic [DB_W-1:0] db_cnt;
  logic            accept, rise, fall;

  // NOTE: the synchronizer resets to the idle pin level, not 0, so that a button
  // held through reset is seen as a fresh transition once reset lifts.
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1 <= IDLE_PIN;
      sync2 <= IDLE_PIN;
    end else begin
      // NOTE: non-blocking assignments let sync2 take the old sync1, forming two real flops.
      sync1 <= BTN;
      sync2 <= sync1;
    end
  end

  assign s      = ACTIVE_LOW ? ~sync2 : sync2;
  assign accept = (s != BTN_LEVEL) && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
  assign rise   = accept & s;
  assign fall   = accept & ~s;

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      db_cnt      <= '0;
      BTN_LEVEL   <= 1'b0;
      PRESS       <= 1'b0;
      RELEASE     <= 1'b0;
      PRESS_COUNT <= '0;
    end else begin
      PRESS   <= rise;
      RELEASE <= fall;
      if (s == BTN_LEVEL || accept) db_cnt <= '0;
      else                          db_cnt <= db_cnt + 1'b1;
      if (accept) BTN_LEVEL <= s;
      if (rise)   PRESS_COUNT <= PRESS_COUNT + 8'd1;
    end
  end

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= RELEASED;
`ifdef PANO_BUTTON_LONG_PRESS_EN
      hold_cnt   <= '0;
      LONG_PRESS <= 1'b0;
`endif
    end else begin
      state      <= state_d;
`ifdef PANO_BUTTON_LONG_PRESS_EN
      hold_cnt   <= hold_cnt_d;
      LONG_PRESS <= long_d;
`endif
    end
  end

  // NOTE: every signal driven here gets its default first so no latch is inferred.
  always_comb begin
    state_d = state;
`ifdef PANO_BUTTON_LONG_PRESS_EN
    hold_cnt_d = hold_cnt;
    long_d     = 1'b0;
`endif
    case (state)
      RELEASED: begin
        if (rise) begin
          state_d = PRESSED;
`ifdef PANO_BUTTON_LONG_PRESS_EN
          hold_cnt_d = '0;
`endif
        end
      end
      PRESSED: begin
        // A release accepted on the completing edge takes priority over LONG_PRESS.
        if (fall) begin
          state_d = RELEASED;
`ifdef PANO_BUTTON_LONG_PRESS_EN
        end else if (hold_cnt == HOLD_W'(LONG_PRESS_CYCLES - 1)) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt + 1'b1;
`endif
        end
      end
`ifdef PANO_BUTTON_LONG_PRESS_EN
      LONG_HELD: begin
        if (fall) state_d = RELEASED;
      end
`endif
      default: state_d = RELEASED;
    endcase
  end

`ifndef PANO_BUTTON_LONG_PRESS_EN
  assign LONG_PRESS = 1'b0;
`endif

endmodule
